intr_ctrl: RTL and testbench
============================

# intr_ctrl

Interrupt controller that sequences delivery of synchronized interrupt events to a single CPU-side handler. It sits directly behind a bank of per-source `intr_sync` instances and consumes their `intr_pulse` outputs. It latches each event as pending, applies a software mask, and selects the highest-priority unmasked source. It presents that source through a request/acknowledge/end-of-interrupt handshake.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 2..32
- `ID_W`, `$clog2(NUM_SRC)`: width of `intr_id`
- `ACK_TIMEOUT`, 255: cycles in REQ without ack before abort; used only with the timeout feature
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `intr_pulse` in NUM_SRC: one-cycle event pulses from `intr_sync` instances, one bit per source
- `mask_wr` in 1: write strobe for the mask register
- `mask_wdata` in NUM_SRC: new mask value; 1 = source masked
- `mask` out NUM_SRC: current mask register
- `pending` out NUM_SRC: latched, not-yet-acknowledged events, mask-independent
- `intr_req` out 1: request to CPU
- `intr_id` out ID_W: index of the requested or in-service source
- `intr_ack` in 1: CPU accepts the current request
- `intr_eoi` in 1: CPU finished servicing
- `in_service` out 1: high in SERVICE state
- `timeout_err` out 1: sticky abort flag; cleared by a `mask_wr` pulse

## Operation
- `pending[i]` is set at the edge where `intr_pulse[i]`=1.
- `pending[i]` is cleared at the edge where an ack is accepted for id i.
- Set and clear of the same bit in the same cycle: set wins, so the event is not lost.
- Priority: lowest index wins. Candidate vector = `pending & ~mask`.
- FSM states:
  - IDLE: if the candidate vector is nonzero, go to REQ and latch `intr_id` = highest-priority candidate.
  - REQ: `intr_req`=1. `intr_id` is frozen, even if a higher-priority source arrives or the mask changes. On `intr_ack`, clear `pending[intr_id]` and go to SERVICE.
  - SERVICE: `intr_req`=0, `in_service`=1, `intr_id` held. On `intr_eoi`, go to IDLE.
- Ignored inputs:
  - `intr_ack` outside REQ.
  - `intr_eoi` outside SERVICE.
  - `intr_ack` and `intr_eoi` asserted together in REQ: the ack is taken, the eoi is ignored.
- `mask_wr` updates `mask` at the edge. It never aborts a request or service already in flight.
- Reset values:
  - `mask` = all ones (all masked).
  - `pending`, `intr_req`, `in_service`, `timeout_err` = 0.
  - `intr_id` = 0.
  - State = IDLE.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous); pending events are discarded.

## Timing
- Pulse sampled at edge E0 makes `pending` visible after E0. `intr_req` and `intr_id` are valid after E1. Minimum latency is 2 edges.
- Ack sampled at edge Ea: `intr_req` falls, `in_service` rises and the pending bit clears, all after Ea.
- EOI sampled at edge Ee: state returns to IDLE after Ee. The next `intr_req` is no earlier than after Ee+1, which guarantees at least one IDLE cycle.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- `INTR_CTRL_ACK_TIMEOUT_EN` defined:
  - An 8..16-bit counter runs while in REQ.
  - When it reaches `ACK_TIMEOUT` without an ack, the FSM returns to IDLE with `pending` left set, so the source is re-arbitrated.
  - `timeout_err` is set.
  - The counter clears on entry to REQ.
- Not defined: REQ waits indefinitely, no counter is built, and `timeout_err` is tied to 0.

## Structure
- Package `intr_ctrl_pkg`: FSM state enum (IDLE, REQ, SERVICE) and the default `ACK_TIMEOUT` constant.
- Sub-module `intr_prio_enc`: combinational lowest-index-first priority encoder, NUM_SRC wide. Outputs `valid` and `id`.
- The `intr_sync` instances stay outside this block; the integrator wires their pulses to `intr_pulse`.

## Test plan
- Single event: after reset, write mask=0x00, pulse `intr_pulse`=0x08. Required: `intr_req`=1, `intr_id`=3 two edges later. Ack gives `pending`=0x00 and `in_service`=1. EOI returns to IDLE.
- Priority and freeze:
  - Pulse 0x20, then pulse 0x02 once REQ is already up. Required: `intr_id` stays 5 until ack.
  - After EOI, the next request has `intr_id`=1.
- Masking:
  - With mask=0xFF, pulse 0x01. Required: `pending`=0x01 and `intr_req` stays 0.
  - Write mask=0xFE. Required: request for id 0 two edges later.
- Simultaneous set and clear: pulse source 4 in the same cycle as the ack for id 4. Required: `pending[4]`=1 afterwards, and a second request for id 4 after EOI.
- Reset mid-service: assert `rst` while in SERVICE with `pending`=0x0C. Required: all outputs zero, `mask`=0xFF, no request after release.
- Timeout (macro on, `ACK_TIMEOUT`=10): hold off ack. Required: `intr_req` drops after 10 REQ cycles, `timeout_err`=1, and the request reasserts with the same id.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
//   state_e           : controller FSM state encoding
//   AckTimeoutDefault : default number of REQ cycles before an unacknowledged request is aborted
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    localparam int unsigned AckTimeoutDefault = 255;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   valid : at least one request bit is set
//   id    : index of the lowest set bit (0 when none set)
module intr_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Walk from the top down so the lowest set index is written last.
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches event pulses as pending, masks them, and presents the
// highest-priority unmasked source to the CPU through a req/ack/eoi handshake.
//   clk, rst                : clock, asynchronous active-high reset
//   intr_pulse              : one-cycle event pulses, one bit per source
//   mask_wr, mask_wdata     : mask register write (1 = masked); also clears timeout_err
//   mask, pending           : current mask and latched events
//   intr_req, intr_id       : request to CPU and the requested / in-service source
//   intr_ack, intr_eoi      : CPU accept and end-of-interrupt
//   in_service, timeout_err : SERVICE state flag, sticky ack-timeout flag
// Optional feature: define INTR_CTRL_ACK_TIMEOUT_EN to abort a request that is not
// acknowledged within ACK_TIMEOUT cycles; otherwise REQ waits forever and timeout_err is 0.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned ID_W        = $clog2(NUM_SRC),
    parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] intr_pulse,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               intr_req,
    output logic [ID_W-1:0]    intr_id,
    input  logic               intr_ack,
    input  logic               intr_eoi,
    output logic               in_service,
    output logic               timeout_err
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    intr_id_q, intr_id_d;
    logic [NUM_SRC-1:0] ack_clr;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;
    logic               ack_take;
    logic               timeout_hit;

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (pending_q & ~mask_q),
        .valid (cand_valid),
        .id    (cand_id)
    );

    assign ack_take = (state_q == StReq) && intr_ack;

`ifdef INTR_CTRL_ACK_TIMEOUT_EN
    localparam int unsigned CntRaw = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // The ack wins over a timeout landing on the same edge.
    assign timeout_hit = (state_q == StReq) && !intr_ack && (cnt_q == CntW'(ACK_TIMEOUT - 1));

    always_comb begin
        cnt_d = (state_q == StReq) ? cnt_q + 1'b1 : '0;
        err_d = err_q;
        if (mask_wr) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '1;
            intr_id_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            intr_id_q <= intr_id_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        intr_id_d = intr_id_q;
        mask_d    = mask_wr ? mask_wdata : mask_q;
        ack_clr   = ack_take ? (NUM_SRC'(1) << intr_id_q) : '0;
        // A new pulse overrides the ack clear so the event is not lost.
        pending_d = (pending_q & ~ack_clr) | intr_pulse;

        unique case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    state_d   = StReq;
                    intr_id_d = cand_id;
                end
            end
            StReq: begin
                if (ack_take) begin
                    state_d = StService;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (intr_eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs, decoded from registers only
    always_comb begin
        intr_req   = (state_q == StReq);
        in_service = (state_q == StService);
        intr_id    = intr_id_q;
        mask       = mask_q;
        pending    = pending_q;
    end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] intr_pulse;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       intr_req;
    logic [2:0] intr_id;
    logic       intr_ack;
    logic       intr_eoi;
    logic       in_service;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ids[$];
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    intr_ctrl #(
        .NUM_SRC     (8),
        .ID_W        (3),
        .ACK_TIMEOUT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .intr_pulse  (intr_pulse),
        .mask_wr     (mask_wr),
        .mask_wdata  (mask_wdata),
        .mask        (mask),
        .pending     (pending),
        .intr_req    (intr_req),
        .intr_id     (intr_id),
        .intr_ack    (intr_ack),
        .intr_eoi    (intr_eoi),
        .in_service  (in_service),
        .timeout_err (timeout_err)
    );

    // Monitor: every new request must match the next expected id in the scoreboard.
    always @(negedge clk) begin
        int e;
        if (intr_req && !req_prev) begin
            n_cmp++;
            if (exp_ids.size() == 0) begin
                n_err++;
                $display("FAIL req_id: unexpected request id=%0d, required none", intr_id);
            end else begin
                e = exp_ids.pop_front();
                if (int'(intr_id) != e) begin
                    n_err++;
                    $display("FAIL req_id: got %0d, required %0d", intr_id, e);
                end
            end
        end
        req_prev = intr_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        intr_pulse = v;
        tick();
        intr_pulse = '0;
    endtask

    task automatic mask_write(input logic [7:0] v);
        mask_wr    = 1'b1;
        mask_wdata = v;
        tick();
        mask_wr    = 1'b0;
    endtask

    task automatic ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic eoi();
        intr_eoi = 1'b1;
        tick();
        intr_eoi = 1'b0;
    endtask

    initial begin
        logic held;
        rst        = 1'b1;
        intr_pulse = '0;
        mask_wr    = 1'b0;
        mask_wdata = '0;
        intr_ack   = 1'b0;
        intr_eoi   = 1'b0;
        tick();
        tick();
        check("rst_mask", mask, 8'hFF);
        check("rst_pending", pending, 8'h00);
        check("rst_req", intr_req, 1'b0);
        check("rst_in_service", in_service, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_id", intr_id, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single event
        mask_write(8'h00);
        check("mask_wr", mask, 8'h00);
        exp_ids.push_back(3);
        pulse(8'h08);
        check("single_pend", pending, 8'h08);
        check("single_req_e0", intr_req, 1'b0);
        tick();
        check("single_req_e1", intr_req, 1'b1);
        check("single_id", intr_id, 3'd3);
        ack();
        check("single_ack_pend", pending, 8'h00);
        check("single_ack_insvc", in_service, 1'b1);
        check("single_ack_req", intr_req, 1'b0);
        eoi();
        check("single_eoi_insvc", in_service, 1'b0);
        tick();
        check("single_idle_req", intr_req, 1'b0);

        // Priority and freeze
        exp_ids.push_back(5);
        pulse(8'h20);
        tick();
        check("freeze_req", intr_req, 1'b1);
        pulse(8'h02);
        tick();
        check("freeze_id_hp", intr_id, 3'd5);
        check("freeze_pend", pending, 8'h22);
        mask_write(8'hFF);
        check("freeze_id_mask", intr_id, 3'd5);
        check("freeze_req_mask", intr_req, 1'b1);
        mask_write(8'h00);
        exp_ids.push_back(1);
        ack();
        check("freeze_ack_id", intr_id, 3'd5);
        check("freeze_ack_pend", pending, 8'h02);
        eoi();
        check("freeze_idle_gap", intr_req, 1'b0);
        tick();
        check("next_req", intr_req, 1'b1);
        check("next_id", intr_id, 3'd1);
        ack();
        eoi();

        // Masking
        mask_write(8'hFF);
        pulse(8'h01);
        tick();
        tick();
        check("masked_pend", pending, 8'h01);
        check("masked_req", intr_req, 1'b0);
        exp_ids.push_back(0);
        mask_write(8'hFE);
        check("unmask_req_e0", intr_req, 1'b0);
        tick();
        check("unmask_req_e1", intr_req, 1'b1);
        check("unmask_id", intr_id, 3'd0);
        ack();
        eoi();

        // Simultaneous set and clear, plus ignored eoi in REQ
        mask_write(8'h00);
        exp_ids.push_back(4);
        pulse(8'h10);
        tick();
        check("sim_req", intr_req, 1'b1);
        eoi();
        check("eoi_in_req_ignored", intr_req, 1'b1);
        intr_ack   = 1'b1;
        intr_pulse = 8'h10;
        tick();
        intr_ack   = 1'b0;
        intr_pulse = '0;
        check("sim_pend_kept", pending, 8'h10);
        check("sim_insvc", in_service, 1'b1);
        exp_ids.push_back(4);
        eoi();
        tick();
        check("sim_rereq", intr_req, 1'b1);
        check("sim_rereq_id", intr_id, 3'd4);
        intr_ack = 1'b1;
        intr_eoi = 1'b1;
        tick();
        intr_ack = 1'b0;
        intr_eoi = 1'b0;
        check("ack_eoi_insvc", in_service, 1'b1);
        eoi();

        // Reset mid-service
        exp_ids.push_back(1);
        pulse(8'h0E);
        tick();
        ack();
        check("mid_pend", pending, 8'h0C);
        check("mid_insvc", in_service, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pend", pending, 8'h00);
        check("arst_mask", mask, 8'hFF);
        check("arst_insvc", in_service, 1'b0);
        check("arst_req", intr_req, 1'b0);
        check("arst_id", intr_id, 3'd0);
        check("arst_terr", timeout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("post_rst_req", intr_req, 1'b0);
        check("post_rst_pend", pending, 8'h00);

        // Ack timeout
        mask_write(8'h00);
        exp_ids.push_back(2);
        pulse(8'h04);
        tick();
        check("to_req", intr_req, 1'b1);
        held = 1'b1;
`ifdef INTR_CTRL_ACK_TIMEOUT_EN
        for (int k = 0; k < 9; k++) begin
            tick();
            if (!intr_req) held = 1'b0;
        end
        check("to_held", held, 1'b1);
        tick();
        check("to_req_drop", intr_req, 1'b0);
        check("to_err", timeout_err, 1'b1);
        check("to_pend", pending, 8'h04);
        exp_ids.push_back(2);
        tick();
        check("to_rereq", intr_req, 1'b1);
        check("to_rereq_id", intr_id, 3'd2);
        ack();
        eoi();
        mask_write(8'h00);
        check("to_err_clr", timeout_err, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!intr_req) held = 1'b0;
        end
        check("no_to_held", held, 1'b1);
        check("no_to_err", timeout_err, 1'b0);
        ack();
        eoi();
`endif

        tick();
        tick();
        n_cmp++;
        if (exp_ids.size() != 0) begin
            n_err++;
            $display("FAIL req_missing: %0d expected requests never seen, required 0",
                     exp_ids.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
